// File: rtl/dram_sequencer.sv
// DRAM timing engine for the Zorro II FastRAM card: RAS/CAS/WE sequencing plus CAS-before-RAS refresh.
// Access ACK arrives 2 cycles after a qualified request; each queued refresh ahead of it adds 5 cycles.
module dram_sequencer #(
  parameter int REFRESH_INTERVAL = 108,
  parameter int MAX_PENDING      = 4
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        REQ,
  input  logic        ASn,
  input  logic        RWn,
  input  logic        UDSn,
  input  logic        LDSn,
  input  logic [22:1] ADDR,
  output logic [9:0]  MADDR,
  output logic [3:0]  RASn,
  output logic        UCASn,
  output logic        LCASn,
  output logic        MEMWn,
  output logic        ACK,
  output logic        REF_BUSY
);

  localparam int TW = $clog2(REFRESH_INTERVAL);
  localparam int PW = $clog2(MAX_PENDING + 1);

  typedef enum logic [2:0] {IDLE, ROW, COL, PRE, REF_CAS, REF_RAS1, REF_RAS2} state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [PW-1:0] pending;
  logic          tick;
  logic          pend_full;
  logic          ref_start;

  assign tick      = (timer == TW'(REFRESH_INTERVAL - 1));
  assign pend_full = (pending == PW'(MAX_PENDING));
  // A full backlog beats a waiting access; otherwise refresh only fills idle bus time.
  assign ref_start = (state == IDLE) && (pend_full || (!(REQ && !ASn) && (pending != '0)));

  // ADDR[22:21] = 01,10,11,00 map to RASn bit 0,1,2,3.
  function automatic logic [3:0] bank_ras(input logic [1:0] b);
    return ~(4'b0001 << (b - 2'd1));
  endfunction

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      timer   <= '0;
      pending <= '0;
    end else begin
      timer <= tick ? '0 : timer + TW'(1);
      if (ref_start && !tick)
        pending <= pending - PW'(1);
      else if (tick && !ref_start && !pend_full)
        pending <= pending + PW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state    <= IDLE;
      MADDR    <= '0;
      RASn     <= 4'hF;
      UCASn    <= 1'b1;
      LCASn    <= 1'b1;
      MEMWn    <= 1'b1;
      ACK      <= 1'b0;
      REF_BUSY <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          MADDR <= ADDR[20:11];
          if (ref_start) begin
            state    <= REF_CAS;
            UCASn    <= 1'b0;
            LCASn    <= 1'b0;
            MEMWn    <= 1'b1;
            REF_BUSY <= 1'b1;
          end else if (REQ && !ASn) begin
            state <= ROW;
            RASn  <= bank_ras(ADDR[22:21]);
          end
        end
        ROW: begin
          MADDR <= ADDR[10:1];
          if (ASn) begin
            state <= PRE;
            RASn  <= 4'hF;
            MEMWn <= 1'b1;
          end else begin
            state <= COL;
            MEMWn <= RWn;
            ACK   <= 1'b1;
            UCASn <= UDSn;
            LCASn <= LDSn;
          end
        end
        COL: begin
          if (ASn) begin
            state <= PRE;
            RASn  <= 4'hF;
            UCASn <= 1'b1;
            LCASn <= 1'b1;
            MEMWn <= 1'b1;
            ACK   <= 1'b0;
          end else begin
            // Strobes latch low once seen so late write strobes still get CAS.
            UCASn <= UCASn & UDSn;
            LCASn <= LCASn & LDSn;
            MEMWn <= RWn;
          end
        end
        PRE: begin
          state <= IDLE;
          RASn  <= 4'hF;
          UCASn <= 1'b1;
          LCASn <= 1'b1;
          MEMWn <= 1'b1;
          ACK   <= 1'b0;
        end
        REF_CAS: begin
          state <= REF_RAS1;
          RASn  <= 4'h0;
        end
        REF_RAS1: state <= REF_RAS2;
        REF_RAS2: begin
          state    <= PRE;
          RASn     <= 4'hF;
          UCASn    <= 1'b1;
          LCASn    <= 1'b1;
          REF_BUSY <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_sequencer.sv
// Scoreboarded bench for dram_sequencer: timed expectations queued at stimulus, checked per cycle.
module tb_dram_sequencer;

  logic        CLK = 1'b0;
  logic        RESETn;
  logic        REQ, ASn, RWn, UDSn, LDSn;
  logic [22:1] ADDR;
  logic [9:0]  MADDR;
  logic [3:0]  RASn;
  logic        UCASn, LCASn, MEMWn, ACK, REF_BUSY;

  dram_sequencer dut (
    .CLK(CLK), .RESETn(RESETn), .REQ(REQ), .ASn(ASn), .RWn(RWn), .UDSn(UDSn),
    .LDSn(LDSn), .ADDR(ADDR), .MADDR(MADDR), .RASn(RASn), .UCASn(UCASn),
    .LCASn(LCASn), .MEMWn(MEMWn), .ACK(ACK), .REF_BUSY(REF_BUSY)
  );

  always #5 CLK = ~CLK;

  localparam int S_RAS = 0, S_UCAS = 1, S_LCAS = 2, S_MEMW = 3, S_ACK = 4;
  localparam int S_REF = 5, S_MADDR = 6, S_PEND = 7, S_TIMER = 8;

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] val;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc;

  always @(posedge CLK or negedge RESETn)
    if (!RESETn) cyc <= 0;
    else         cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic sb_push(input int c, input int sig, input logic [31:0] val, input string tag);
    exp_t e;
    e.cyc = c; e.sig = sig; e.val = val; e.tag = tag;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] obs(input int sig);
    case (sig)
      S_RAS:   return 32'(RASn);
      S_UCAS:  return 32'(UCASn);
      S_LCAS:  return 32'(LCASn);
      S_MEMW:  return 32'(MEMWn);
      S_ACK:   return 32'(ACK);
      S_REF:   return 32'(REF_BUSY);
      S_MADDR: return 32'(MADDR);
      S_PEND:  return 32'(dut.pending);
      default: return 32'(dut.timer);
    endcase
  endfunction

  function automatic logic [3:0] ras_for(input logic [1:0] bank);
    case (bank)
      2'b01:   return 4'b1110;
      2'b10:   return 4'b1101;
      2'b11:   return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  function automatic logic [22:1] bus_addr(input logic [23:0] byte_addr);
    return byte_addr[22:1];
  endfunction

  function automatic logic [9:0] row_of(input logic [23:0] byte_addr);
    return 10'((byte_addr >> 11) & 24'h3FF);
  endfunction

  function automatic logic [9:0] col_of(input logic [23:0] byte_addr);
    return 10'((byte_addr >> 1) & 24'h3FF);
  endfunction

  always @(negedge CLK) begin
    if (RESETn) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc == cyc) begin
          check_val(sb[i].tag, obs(sb[i].sig), sb[i].val);
          sb.delete(i);
        end
      end
      check_val("ack_ref_excl", 32'(ACK & REF_BUSY), 32'd0);
      check_val("pend_le_max", 32'(dut.pending <= 3'd4), 32'd1);
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) step();
  endtask

  task automatic bus_idle();
    REQ = 1'b0; ASn = 1'b1; RWn = 1'b1; UDSn = 1'b1; LDSn = 1'b1;
  endtask

  task automatic do_access(input logic [22:1] a, input logic rw, input int exp_lat, input logic exp_ref);
    int   n;
    logic saw_ref;
    ADDR = a; RWn = rw; UDSn = 1'b0; LDSn = 1'b0; REQ = 1'b1; ASn = 1'b0;
    n = 0;
    saw_ref = 1'b0;
    do begin
      step();
      n++;
      if (REF_BUSY) saw_ref = 1'b1;
    end while (!ACK && n < 20);
    check_val("acc_latency", 32'(n), 32'(exp_lat));
    check_val("acc_refresh_first", 32'(saw_ref), 32'(exp_ref));
    check_val("acc_ras", 32'(RASn), 32'(ras_for(a[22:21])));
    check_val("acc_col", 32'(MADDR), 32'(a[10:1]));
    check_val("acc_memw", 32'(MEMWn), 32'(rw));
    bus_idle();
    step();
    step();
  endtask

  initial begin
    int           c;
    int           t4;
    logic [23:0]  b;

    RESETn = 1'b0;
    ADDR = '0;
    bus_idle();
    #23;
    check_val("rst_ras", 32'(RASn), 32'hF);
    check_val("rst_cas", 32'({UCASn, LCASn}), 32'h3);
    check_val("rst_memw", 32'(MEMWn), 32'd1);
    check_val("rst_ack_ref", 32'({ACK, REF_BUSY}), 32'd0);
    check_val("rst_maddr", 32'(MADDR), 32'd0);
    check_val("rst_pend", 32'(dut.pending), 32'd0);
    RESETn = 1'b1;

    // Idle: first tick at edge 108, refresh issued on the next decision.
    sb_push(50,  S_TIMER, 50, "timer_run");
    sb_push(107, S_PEND,  0,  "pend_before_tick");
    sb_push(108, S_PEND,  1,  "pend_at_tick");
    sb_push(109, S_REF,   1,  "ref_cas_busy");
    sb_push(109, S_UCAS,  0,  "ref_cas_u");
    sb_push(109, S_LCAS,  0,  "ref_cas_l");
    sb_push(109, S_RAS,   4'hF, "ref_cas_ras_high");
    sb_push(109, S_PEND,  0,  "pend_after_ref");
    sb_push(110, S_RAS,   0,  "ref_ras1");
    sb_push(111, S_RAS,   0,  "ref_ras2");
    sb_push(111, S_UCAS,  0,  "ref_cas_held");
    sb_push(112, S_RAS,   4'hF, "ref_pre_ras");
    sb_push(112, S_UCAS,  1,  "ref_pre_cas");
    sb_push(112, S_REF,   0,  "ref_pre_busy");

    wait_cyc(20);
    b = 24'h2AB800;
    ADDR = bus_addr(b);
    sb_push(21, S_MADDR, 32'(row_of(b)), "idle_row_follow");

    // Read at $234567.
    wait_cyc(120);
    c = cyc;
    b = 24'h234567;
    ADDR = bus_addr(b); RWn = 1'b1; UDSn = 1'b0; LDSn = 1'b0; REQ = 1'b1; ASn = 1'b0;
    sb_push(c + 1, S_RAS,   4'b1110, "rd_ras");
    sb_push(c + 1, S_MADDR, 32'(row_of(b)), "rd_row");
    sb_push(c + 1, S_ACK,   0, "rd_ack_row");
    sb_push(c + 2, S_MADDR, 32'(col_of(b)), "rd_col");
    sb_push(c + 2, S_ACK,   1, "rd_ack");
    sb_push(c + 2, S_UCAS,  0, "rd_ucas");
    sb_push(c + 2, S_LCAS,  0, "rd_lcas");
    sb_push(c + 2, S_MEMW,  1, "rd_memw");
    sb_push(c + 3, S_RAS,   4'b1110, "rd_ras_hold");
    sb_push(c + 4, S_RAS,   4'hF, "rd_pre_ras");
    sb_push(c + 4, S_UCAS,  1, "rd_pre_ucas");
    sb_push(c + 4, S_ACK,   0, "rd_pre_ack");
    wait_cyc(c + 3);
    bus_idle();

    // Write to $800000 with a late lower strobe.
    wait_cyc(130);
    c = cyc;
    ADDR = bus_addr(24'h800000); RWn = 1'b0; UDSn = 1'b1; LDSn = 1'b1; REQ = 1'b1; ASn = 1'b0;
    sb_push(c + 1, S_RAS,  4'b0111, "wr_ras");
    sb_push(c + 2, S_MEMW, 0, "wr_memw");
    sb_push(c + 2, S_ACK,  1, "wr_ack");
    sb_push(c + 2, S_LCAS, 1, "wr_lcas_wait");
    sb_push(c + 3, S_LCAS, 0, "wr_lcas_late");
    sb_push(c + 3, S_UCAS, 1, "wr_ucas_idle");
    sb_push(c + 4, S_LCAS, 0, "wr_lcas_hold");
    sb_push(c + 5, S_MEMW, 1, "wr_pre_memw");
    sb_push(c + 5, S_LCAS, 1, "wr_pre_lcas");
    wait_cyc(c + 2);
    LDSn = 1'b0;
    wait_cyc(c + 4);
    bus_idle();

    // Long access across two ticks; release so the refresh starts on a tick edge.
    wait_cyc(200);
    b = 24'h634566;
    ADDR = bus_addr(b); RWn = 1'b1; UDSn = 1'b0; LDSn = 1'b1; REQ = 1'b1; ASn = 1'b0;
    sb_push(201, S_RAS,  4'b1011, "long_ras");
    sb_push(202, S_UCAS, 0, "long_ucas");
    sb_push(202, S_LCAS, 1, "long_lcas");
    sb_push(216, S_PEND, 1, "long_pend1");
    sb_push(300, S_ACK,  1, "long_ack");
    sb_push(324, S_PEND, 2, "long_pend2");
    sb_push(431, S_PEND, 2, "coinc_pend_before");
    sb_push(432, S_REF,  1, "coinc_ref_start");
    sb_push(432, S_PEND, 2, "coinc_pend_net0");
    sb_push(433, S_RAS,  0, "coinc_ras");
    sb_push(436, S_REF,  0, "coinc_gap");
    sb_push(437, S_PEND, 1, "drain_pend1");
    sb_push(442, S_PEND, 0, "drain_pend0");
    sb_push(446, S_REF,  0, "drain_done");
    wait_cyc(429);
    bus_idle();

    // Saturate the backlog with back-to-back accesses, then see the forced refresh.
    wait_cyc(450);
    check_val("sat_pend_start", 32'(dut.pending), 32'd0);
    t4 = ((cyc / 108) + 1) * 108 + 3 * 108;
    while (cyc < t4)
      do_access(22'($urandom), 1'($urandom_range(0, 1)), 2, 1'b0);
    check_val("sat_pend_full", 32'(dut.pending), 32'd4);
    do_access(22'($urandom), 1'b1, 7, 1'b1);
    check_val("sat_pend_after", 32'(dut.pending), 32'd3);
    repeat (20) step();
    check_val("sat_pend_drained", 32'(dut.pending), 32'd0);

    // Asynchronous reset in the middle of COL.
    ADDR = bus_addr(24'h400010); RWn = 1'b0; UDSn = 1'b0; LDSn = 1'b0; REQ = 1'b1; ASn = 1'b0;
    step();
    step();
    check_val("ar_col_ack", 32'(ACK), 32'd1);
    #3;
    RESETn = 1'b0;
    #1;
    check_val("ar_ras", 32'(RASn), 32'hF);
    check_val("ar_cas", 32'({UCASn, LCASn}), 32'h3);
    check_val("ar_ack", 32'(ACK), 32'd0);
    check_val("ar_memw", 32'(MEMWn), 32'd1);
    bus_idle();
    @(posedge CLK);
    #3;
    RESETn = 1'b1;
    check_val("ar_timer", 32'(dut.timer), 32'd0);
    check_val("ar_pend", 32'(dut.pending), 32'd0);
    do_access(bus_addr(24'h600002), 1'b1, 2, 1'b0);

    repeat (3) step();
    check_val("sb_drain", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
